// File: rtl/controller_wr_gen2.sv
// rtl/controller_wr_gen2.sv - async FIFO write-side controller: pointers, rdptr sync, full/almost_full/level
// Optional sticky overflow flag with ovf_clr is built when CTRL_WR_OVF_EN is defined.
module controller_wr_gen2 #(
  parameter int PTRWIDTH     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2**PTRWIDTH-2
) (
  input  logic              wclk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [PTRWIDTH:0] rdptr_gray,
`ifdef CTRL_WR_OVF_EN
  input  logic              ovf_clr,
  output logic              overflow,
`endif
  output logic              wr_en,
  output logic [PTRWIDTH-1:0] waddr,
  output logic [PTRWIDTH:0] wrptr_bin,
  output logic [PTRWIDTH:0] wrptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [PTRWIDTH:0] wr_level
);

  typedef logic [PTRWIDTH:0] ptr_t;

  localparam ptr_t AF_THR = ptr_t'(AFULL_THRESH);

  ptr_t wrptr_bin_q, wrptr_bin_d;
  ptr_t wrptr_gray_q, wrptr_gray_d;
  ptr_t sync_q [SYNC_STAGES];
  ptr_t rd_bin;
  ptr_t level_q, level_d;
  logic full_q, full_d;
  logic afull_q, afull_d;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTRWIDTH] = g[PTRWIDTH];
    for (int i = PTRWIDTH-1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Flags look at the post-write pointer so the filling write sets full at its own edge.
  always_comb begin
    wr_en        = push & ~full_q;
    wrptr_bin_d  = wrptr_bin_q + ptr_t'(wr_en);
    wrptr_gray_d = wrptr_bin_d ^ (wrptr_bin_d >> 1);
    rd_bin       = gray2bin(sync_q[SYNC_STAGES-1]);
    level_d      = wrptr_bin_d - rd_bin;
    full_d       = (wrptr_bin_d[PTRWIDTH] != rd_bin[PTRWIDTH]) &&
                   (wrptr_bin_d[PTRWIDTH-1:0] == rd_bin[PTRWIDTH-1:0]);
    afull_d      = (level_d >= AF_THR);
  end

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      wrptr_bin_q  <= '0;
      wrptr_gray_q <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      afull_q      <= 1'b0;
    end else begin
      wrptr_bin_q  <= wrptr_bin_d;
      wrptr_gray_q <= wrptr_gray_d;
      level_q      <= level_d;
      full_q       <= full_d;
      afull_q      <= afull_d;
    end
  end

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rdptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef CTRL_WR_OVF_EN
  logic overflow_q;

  // A new overflow in the same cycle as ovf_clr wins.
  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L)              overflow_q <= 1'b0;
    else if (push && full_q)   overflow_q <= 1'b1;
    else if (ovf_clr)          overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;
`endif

  assign waddr       = wrptr_bin_q[PTRWIDTH-1:0];
  assign wrptr_bin   = wrptr_bin_q;
  assign wrptr_gray  = wrptr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;

endmodule

// File: tb/tb_controller_wr_gen2.sv
// tb/tb_controller_wr_gen2.sv - directed bench with expected-state queue for controller_wr_gen2
// Instance a: default parameters; instance b: SYNC_STAGES=3, AFULL_THRESH=16.
module tb_controller_wr_gen2;

  logic       wclk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [4:0] rdptr_gray = '0;
  logic       ovf_clr = 1'b0;
  logic       wr_en, full, almost_full;
  logic [3:0] waddr;
  logic [4:0] wrptr_bin, wrptr_gray, wr_level;

  logic       b_push = 1'b0;
  logic [4:0] b_rdg = '0;
  logic       b_wr_en, b_full, b_af;
  logic [3:0] b_waddr;
  logic [4:0] b_bin, b_gray, b_level;

`ifdef CTRL_WR_OVF_EN
  logic overflow, b_overflow;
`endif

  always #5 wclk = ~wclk;

  controller_wr_gen2 dut_a (
    .wclk(wclk), .reset_L(reset_L), .push(push), .rdptr_gray(rdptr_gray),
`ifdef CTRL_WR_OVF_EN
    .ovf_clr(ovf_clr), .overflow(overflow),
`endif
    .wr_en(wr_en), .waddr(waddr), .wrptr_bin(wrptr_bin), .wrptr_gray(wrptr_gray),
    .full(full), .almost_full(almost_full), .wr_level(wr_level)
  );

  controller_wr_gen2 #(.PTRWIDTH(4), .SYNC_STAGES(3), .AFULL_THRESH(16)) dut_b (
    .wclk(wclk), .reset_L(reset_L), .push(b_push), .rdptr_gray(b_rdg),
`ifdef CTRL_WR_OVF_EN
    .ovf_clr(1'b0), .overflow(b_overflow),
`endif
    .wr_en(b_wr_en), .waddr(b_waddr), .wrptr_bin(b_bin), .wrptr_gray(b_gray),
    .full(b_full), .almost_full(b_af), .wr_level(b_level)
  );

  typedef struct {
    logic [4:0] wb;
    logic [4:0] wg;
    logic [4:0] lvl;
    logic       f;
    logic       af;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         m_wptr = 0;
  logic [4:0] m_s0 = '0, m_s1 = '0;
  logic       m_full = 1'b0;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [4:0] g);
    int b = 0;
    for (int i = 0; i < 32; i++) if (to_gray(i) == g) b = i;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wptr = 0; m_s0 = '0; m_s1 = '0; m_full = 1'b0;
    sb.delete();
  endtask

  // One wclk cycle: drive, predict, check wr_en/waddr before the edge, compare state after it.
  task automatic step(input logic p, input logic [4:0] rg);
    exp_t e;
    int   acc, nxt, lvl;
    push = p; rdptr_gray = rg;
    #1;
    acc = (p && !m_full) ? 1 : 0;
    chk("wr_en", 32'(wr_en), 32'(acc));
    chk("waddr", 32'(waddr), 32'(m_wptr % 16));
    nxt = (m_wptr + acc) % 32;
    lvl = (nxt - from_gray(m_s1) + 32) % 32;
    e.wb = 5'(nxt); e.wg = to_gray(nxt); e.lvl = 5'(lvl);
    e.f = (lvl == 16); e.af = (lvl >= 14);
    sb.push_back(e);
    m_s1 = m_s0; m_s0 = rg;
    m_wptr = nxt; m_full = e.f;
    @(posedge wclk); #1;
    e = sb.pop_front();
    chk("wrptr_bin", 32'(wrptr_bin), 32'(e.wb));
    chk("wrptr_gray", 32'(wrptr_gray), 32'(e.wg));
    chk("wr_level", 32'(wr_level), 32'(e.lvl));
    chk("full", 32'(full), 32'(e.f));
    chk("almost_full", 32'(almost_full), 32'(e.af));
  endtask

  initial begin
    logic [4:0] prev_g, prev_b;
    logic       saw_wrap;
    int         dly;

    repeat (2) @(posedge wclk);
    #1;
    chk("rst_bin", 32'(wrptr_bin), 0);
    chk("rst_full", 32'(full), 0);
    reset_L = 1'b1;
    model_reset();

    // 1: reset mid-run at wrptr_bin=9
    for (int i = 0; i < 9; i++) step(1'b1, 5'd0);
    chk("pre_rst_bin", 32'(wrptr_bin), 9);
    push = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    chk("arst_bin", 32'(wrptr_bin), 0);
    chk("arst_gray", 32'(wrptr_gray), 0);
    chk("arst_level", 32'(wr_level), 0);
    chk("arst_waddr", 32'(waddr), 0);
    @(posedge wclk); #1;
    chk("hold_rst_bin", 32'(wrptr_bin), 0);
    chk("hold_rst_full", 32'(full), 0);
    chk("hold_rst_af", 32'(almost_full), 0);
`ifdef CTRL_WR_OVF_EN
    chk("rst_ovf", 32'(overflow), 0);
`endif
    push = 1'b0;
    reset_L = 1'b1;
    model_reset();
    #1 chk("first_waddr", 32'(waddr), 0);

    // 2: fill with 16 pushes
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'd0);
      chk("fill_level", 32'(wr_level), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 14));
      chk("fill_full", 32'(full), 32'(i == 16));
    end
    chk("full_bin", 32'(wrptr_bin), 32'h10);

    // 3: push while full
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0);
    chk("blocked_bin", 32'(wrptr_bin), 16);
`ifdef CTRL_WR_OVF_EN
    chk("ovf_set", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step(1'b1, 5'd0);
    chk("ovf_set_prio", 32'(overflow), 1);
    step(1'b0, 5'd0);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
`endif

    // 4: read pointer to 4 -> full falls 3 edges later
    step(1'b0, 5'b00110);
    chk("rel_e1_full", 32'(full), 1);
    step(1'b0, 5'b00110);
    chk("rel_e2_full", 32'(full), 1);
    step(1'b0, 5'b00110);
    chk("rel_e3_full", 32'(full), 0);
    chk("rel_level", 32'(wr_level), 12);
    chk("rel_af", 32'(almost_full), 0);

    // 5: 40 pushes with read pointer tracking the writer
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_g = wrptr_gray;
      prev_b = wrptr_bin;
      step(1'b1, to_gray(m_wptr));
      chk("gray_ham", 32'($countones(prev_g ^ wrptr_gray)), 1);
      chk("wrap_no_full", 32'(full), 0);
      if (prev_b == 5'd31 && wrptr_bin == 5'd0) saw_wrap = 1'b1;
    end
    chk("wrap_seen", 32'(saw_wrap), 1);
    push = 1'b0;

    // 6: SYNC_STAGES=3, AFULL_THRESH=16 instance
    for (int i = 1; i <= 16; i++) begin
      b_push = 1'b1;
      @(posedge wclk); #1;
      chk("b_af_eq_full", 32'(b_af), 32'(b_full));
    end
    chk("b_full", 32'(b_full), 1);
    chk("b_bin", 32'(b_bin), 16);
    b_push = 1'b0;
    b_rdg = 5'b00110;
    dly = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge wclk); #1;
      chk("b_af_eq_full_rel", 32'(b_af), 32'(b_full));
      if (!b_full) begin
        dly = n;
        break;
      end
    end
    chk("b_release_delay", 32'(dly), 4);
    chk("b_level", 32'(b_level), 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
